// File: rtl/alu_pkg.sv
// Shared ALU issue-stage types: ALU control encodings, main-control ALUOp
// classes, funct3 constants and the buffered issue entry layout.
package alu_pkg;

   localparam int ISSUE_DATA_W = 32;
   localparam int ISSUE_RD_W   = 5;

   // Encodings match the ALU's ctrl input
   typedef enum logic [1:0] {
      ALU_AND = 2'b00,
      ALU_OR  = 2'b01,
      ALU_ADD = 2'b10,
      ALU_SUB = 2'b11
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      OP_LDST  = 2'b00,
      OP_BR    = 2'b01,
      OP_RTYPE = 2'b10,
      OP_ITYPE = 2'b11
   } alu_op_e;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef struct packed {
      alu_ctrl_e               ctrl;
      logic [ISSUE_DATA_W-1:0] in_1;
      logic [ISSUE_DATA_W-1:0] in_2;
      logic [ISSUE_RD_W-1:0]   rd;
      logic                    illegal;
   } issue_entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder: maps ALUOp/funct3/funct7[5] to the
// ALU operation, operand-2 source and an illegal-funct flag.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output alu_ctrl_e  ctrl,
   output logic       use_imm,
   output logic       illegal
);

   // ADD is the fallback for every unrecognised funct combination
   always_comb begin
      ctrl    = ALU_ADD;
      use_imm = 1'b0;
      illegal = 1'b0;
      case (alu_op)
         OP_LDST: use_imm = 1'b1;
         OP_BR:   ctrl    = ALU_SUB;
         OP_RTYPE: begin
            case (funct3)
               F3_ADD:  ctrl    = funct7_5 ? ALU_SUB : ALU_ADD;
               F3_AND:  ctrl    = ALU_AND;
               F3_OR:   ctrl    = ALU_OR;
               default: illegal = 1'b1;
            endcase
         end
         OP_ITYPE: begin
            use_imm = 1'b1;
            case (funct3)
               F3_ADD:  ctrl    = ALU_ADD;
               F3_AND:  ctrl    = ALU_AND;
               F3_OR:   ctrl    = ALU_OR;
               default: illegal = 1'b1;
            endcase
         end
         default: ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Decode/issue stage in front of the ALU. Decodes ALU ctrl and operand 2 at
// push time and buffers the result in a 2-entry skid FIFO. in_ready depends
// only on registered occupancy, never on out_ready.
// Optional feature: define ALU_ISSUE_FWD_EN to add a single-source operand
// forwarding port applied before operand selection.
module alu_ctrl_issue
   import alu_pkg::*;
#(
   parameter int DATA_SIZE = ISSUE_DATA_W,
   parameter int RD_W      = ISSUE_RD_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           alu_op,
   input  logic [2:0]           funct3,
   input  logic                 funct7_5,
   input  logic [DATA_SIZE-1:0] rs1_data,
   input  logic [DATA_SIZE-1:0] rs2_data,
   input  logic [DATA_SIZE-1:0] imm,
   input  logic [RD_W-1:0]      rd_in,
`ifdef ALU_ISSUE_FWD_EN
   input  logic [RD_W-1:0]      rs1_idx,
   input  logic [RD_W-1:0]      rs2_idx,
   input  logic                 fwd_valid,
   input  logic [RD_W-1:0]      fwd_rd,
   input  logic [DATA_SIZE-1:0] fwd_data,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           ctrl,
   output logic [DATA_SIZE-1:0] in_1,
   output logic [DATA_SIZE-1:0] in_2,
   output logic [RD_W-1:0]      rd_out,
   output logic                 illegal
);

   alu_ctrl_e     dec_ctrl;
   logic          dec_use_imm;
   logic          dec_illegal;
   logic [DATA_SIZE-1:0] rs1_eff;
   logic [DATA_SIZE-1:0] rs2_eff;
   issue_entry_t  entry_in;
   issue_entry_t  head;

   issue_entry_t  entry_p0 [2];
   logic          wr_ptr_p0;
   logic          rd_ptr_p0;
   logic [1:0]    count_p0;
   logic          rdy_p0;
   logic [1:0]    count_nxt;
   logic          push;
   logic          pop;

   alu_ctrl_decode u_decode (
      .alu_op   (alu_op_e'(alu_op)),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .ctrl     (dec_ctrl),
      .use_imm  (dec_use_imm),
      .illegal  (dec_illegal)
   );

`ifdef ALU_ISSUE_FWD_EN
   // Forwarded result overrides the register-file value; x0 is never forwarded
   always_comb begin
      rs1_eff = rs1_data;
      rs2_eff = rs2_data;
      if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs1_idx)) rs1_eff = fwd_data;
      if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs2_idx)) rs2_eff = fwd_data;
   end
`else
   // Operands pass through unmodified
   always_comb begin
      rs1_eff = rs1_data;
      rs2_eff = rs2_data;
   end
`endif

   // Assemble the decoded entry that a push writes into the FIFO
   always_comb begin
      entry_in         = '0;
      entry_in.ctrl    = dec_ctrl;
      entry_in.in_1    = rs1_eff;
      entry_in.in_2    = dec_use_imm ? imm : rs2_eff;
      entry_in.rd      = rd_in;
      entry_in.illegal = dec_illegal;
   end

   assign in_ready  = rdy_p0;
   assign out_valid = (count_p0 != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Occupancy update; flush empties the FIFO and wins over a concurrent push
   always_comb begin
      count_nxt = count_p0;
      if (flush) begin
         count_nxt = 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt = count_p0 + 2'd1;
            2'b01:   count_nxt = count_p0 - 2'd1;
            default: count_nxt = count_p0;
         endcase
      end
   end

   // ---- stage p0: FIFO control registers (reset + flush) ----
   // Ready is registered from next occupancy so it stays low throughout reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_p0  <= 2'd0;
         wr_ptr_p0 <= 1'b0;
         rd_ptr_p0 <= 1'b0;
         rdy_p0    <= 1'b0;
      end else begin
         count_p0 <= count_nxt;
         rdy_p0   <= (count_nxt != 2'd2);
         if (flush) begin
            wr_ptr_p0 <= 1'b0;
            rd_ptr_p0 <= 1'b0;
         end else begin
            if (push) wr_ptr_p0 <= ~wr_ptr_p0;
            if (pop)  rd_ptr_p0 <= ~rd_ptr_p0;
         end
      end
   end

   // Entry storage carries no reset; outputs are masked while empty instead
   always_ff @(posedge clk) begin
      if (push && !flush) entry_p0[wr_ptr_p0] <= entry_in;
   end

   assign head    = entry_p0[rd_ptr_p0];
   assign ctrl    = out_valid ? head.ctrl    : 2'b00;
   assign in_1    = out_valid ? head.in_1    : '0;
   assign in_2    = out_valid ? head.in_2    : '0;
   assign rd_out  = out_valid ? head.rd      : '0;
   assign illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: directed steps followed by random
// traffic, compared against a queue-based reference of the issue buffer.
// Forwarding checks are built when ALU_ISSUE_FWD_EN is defined.
module tb_alu_ctrl_issue;

   typedef struct {
      logic [1:0]  ctrl;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, funct7_5;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data, imm;
   logic [4:0]  rd_in;
   logic        out_valid, out_ready;
   logic [1:0]  ctrl;
   logic [31:0] in_1, in_2;
   logic [4:0]  rd_out;
   logic        illegal;
`ifdef ALU_ISSUE_FWD_EN
   logic [4:0]  rs1_idx, rs2_idx, fwd_rd;
   logic        fwd_valid;
   logic [31:0] fwd_data;
`endif

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t q[$];
   bit   m_in_rst = 1'b1;

   alu_ctrl_issue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_in(rd_in),
`ifdef ALU_ISSUE_FWD_EN
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .ctrl(ctrl), .in_1(in_1), .in_2(in_2), .rd_out(rd_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference: what the ALU should be told for the beat on the inputs now
   function automatic exp_t ref_entry();
      exp_t e;
      logic [31:0] a, b;
      a = rs1_data;
      b = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
      if (fwd_valid && fwd_rd != 0 && fwd_rd == rs1_idx) a = fwd_data;
      if (fwd_valid && fwd_rd != 0 && fwd_rd == rs2_idx) b = fwd_data;
`endif
      e.in1 = a;
      e.in2 = (alu_op == 2'd0 || alu_op == 2'd3) ? imm : b;
      e.rd  = rd_in;
      e.ill = 1'b0;
      if (alu_op == 2'd0)      e.ctrl = 2'b10;
      else if (alu_op == 2'd1) e.ctrl = 2'b11;
      else if (funct3 == 3'd0) e.ctrl = (alu_op == 2'd2 && funct7_5) ? 2'b11 : 2'b10;
      else if (funct3 == 3'd7) e.ctrl = 2'b00;
      else if (funct3 == 3'd6) e.ctrl = 2'b01;
      else begin
         e.ctrl = 2'b10;
         e.ill  = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      e = '{ctrl: 2'b00, in1: 32'h0, in2: 32'h0, rd: 5'h0, ill: 1'b0};
      if (q.size() != 0) e = q[0];
      chk("in_ready",  {31'b0, in_ready},  {31'b0, !m_in_rst && q.size() != 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("ctrl",      {30'b0, ctrl},      {30'b0, e.ctrl});
      chk("in_1",      in_1,               e.in1);
      chk("in_2",      in_2,               e.in2);
      chk("rd_out",    {27'b0, rd_out},    {27'b0, e.rd});
      chk("illegal",   {31'b0, illegal},   {31'b0, e.ill});
   endtask

   // One clock: model the handshake, advance the reference, check #1 later
   task automatic cycle();
      bit   push, pop;
      exp_t e;
      push = in_valid && !m_in_rst && q.size() != 2;
      pop  = out_ready && q.size() != 0;
      e    = ref_entry();
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_in_rst = 1'b1;
      end else begin
         if (pop) void'(q.pop_front());
         if (flush) q.delete();
         else if (push) q.push_back(e);
         m_in_rst = 1'b0;
      end
      #1;
      check_outputs();
   endtask

   task automatic beat(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] rd);
      in_valid = 1'b1;
      alu_op = op; funct3 = f3; funct7_5 = f7;
      rs1_data = a; rs2_data = b; imm = im; rd_in = rd;
   endtask

   task automatic rand_beat();
      beat(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
      in_valid = 1'($urandom_range(0, 1));
`ifdef ALU_ISSUE_FWD_EN
      rs1_idx   = 5'($urandom_range(0, 3));
      rs2_idx   = 5'($urandom_range(0, 3));
      fwd_rd    = 5'($urandom_range(0, 3));
      fwd_valid = 1'($urandom_range(0, 1));
      fwd_data  = $urandom;
`endif
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_op = 2'd0; funct3 = 3'd0; funct7_5 = 1'b0;
      rs1_data = '0; rs2_data = '0; imm = '0; rd_in = '0;
`ifdef ALU_ISSUE_FWD_EN
      rs1_idx = '0; rs2_idx = '0; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
      // Reset held, then released and idle
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();

      // R-type SUB with out_ready high
      out_ready = 1'b1;
      beat(2'd2, 3'd0, 1'b1, 32'd10, 32'd3, 32'd99, 5'd7);
      cycle();
      in_valid = 1'b0;
      repeat (2) cycle();

      // I-type OR, then I-type with an undecodable funct3
      beat(2'd3, 3'd6, 1'b0, 32'd1, 32'd2, 32'hF0, 5'd4);
      cycle();
      beat(2'd3, 3'd1, 1'b1, 32'd5, 32'd6, 32'h12, 5'd9);
      cycle();
      in_valid = 1'b0;
      repeat (2) cycle();

      // Stall: three pushes into two slots, then drain in order
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat(2'(i), 3'd7, 1'b0, 32'h100 + i, 32'h200 + i, 32'h300 + i, 5'(i + 1));
         cycle();
      end
      in_valid = 1'b0;
      repeat (2) cycle();
      out_ready = 1'b1;
      repeat (3) cycle();

      // Flush with two entries held while pushing
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         beat(2'd2, 3'd6, 1'b0, 32'h40 + i, 32'h50 + i, 32'h0, 5'(10 + i));
         cycle();
      end
      beat(2'd1, 3'd0, 1'b0, 32'hDEAD, 32'hBEEF, 32'h0, 5'd31);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      repeat (2) cycle();

      // Flush with one entry while a beat is accepted and the head is popped
      beat(2'd0, 3'd0, 1'b0, 32'h11, 32'h22, 32'h33, 5'd3);
      cycle();
      out_ready = 1'b1;
      beat(2'd1, 3'd0, 1'b0, 32'h44, 32'h55, 32'h66, 5'd6);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      repeat (2) cycle();

`ifdef ALU_ISSUE_FWD_EN
      // Forwarding onto rs1, then fwd_rd=0 leaves rs1_data in place
      beat(2'd2, 3'd0, 1'b0, 32'h1, 32'h2, 32'h0, 5'd8);
      rs1_idx = 5'd5; rs2_idx = 5'd6; fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hAA;
      cycle();
      rs1_idx = 5'd0; fwd_rd = 5'd0;
      cycle();
      in_valid = 1'b0; fwd_valid = 1'b0;
      repeat (2) cycle();
`endif

      // Random traffic with occasional flushes and one reset mid-stream
      for (int i = 0; i < 400; i++) begin
         rand_beat();
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         rst_n     = !(i == 200 || i == 201);
         cycle();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
